// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port round-robin arbiter for the shared 16-bit memory bus.
//
// Requester 0 (core fetch/load/store) and requester 1 (debug/DMA) share one
// downstream req/ack bus. At most one transaction is in flight. Downstream request
// fields are registered at grant and held until completion. A watchdog ends a
// transaction that is stalled for TIMEOUT cycles: it returns ERR_RDATA and sets a
// sticky error flag.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   m0_*/m1_*                 requester side: adr, req, write, sel, wdata in;
//                             rdata, ack out (ack is a 1-cycle completion pulse)
//   s_*                       downstream side: adr, req, write, sel, wdata out;
//                             rdata, ack in
//   gnt                       one-hot grant of the in-flight transaction, 0 when idle
//   err, err_clr              sticky timeout flag and its clear
module mem_arbiter #(
  parameter int unsigned TIMEOUT   = 1023,
  parameter logic [15:0] ERR_RDATA = 16'hDEAD
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [17:0] m0_adr,
  input  logic        m0_req,
  input  logic        m0_write,
  input  logic [1:0]  m0_sel,
  input  logic [15:0] m0_wdata,
  output logic [15:0] m0_rdata,
  output logic        m0_ack,
  input  logic [17:0] m1_adr,
  input  logic        m1_req,
  input  logic        m1_write,
  input  logic [1:0]  m1_sel,
  input  logic [15:0] m1_wdata,
  output logic [15:0] m1_rdata,
  output logic        m1_ack,
  output logic [17:0] s_adr,
  output logic        s_req,
  output logic        s_write,
  output logic [1:0]  s_sel,
  output logic [15:0] s_wdata,
  input  logic [15:0] s_rdata,
  input  logic        s_ack,
  output logic [1:0]  gnt,
  output logic        err,
  input  logic        err_clr
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  localparam logic [15:0] CntLast = 16'(TIMEOUT - 1);

  state_e      state_q;
  logic        last_q;  // index of the most recent winner
  logic [15:0] cnt_q;   // cycles spent waiting for s_ack

  logic busy;
  logic timeout_hit;
  logic done;
  logic any_req;
  logic winner;

  assign busy        = (state_q == StBusy);
  // s_ack in the expiry cycle takes priority over the abort.
  assign timeout_hit = busy && !s_ack && (cnt_q == CntLast);
  assign done        = busy && (s_ack || timeout_hit);
  assign any_req     = m0_req | m1_req;
  // On a tie the requester that did not win last time goes next.
  assign winner      = (m0_req && m1_req) ? ~last_q : m1_req;

  assign m0_ack   = done & gnt[0];
  assign m1_ack   = done & gnt[1];
  assign m0_rdata = (gnt[0] && timeout_hit) ? ERR_RDATA : s_rdata;
  assign m1_rdata = (gnt[1] && timeout_hit) ? ERR_RDATA : s_rdata;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      last_q  <= 1'b1;
      cnt_q   <= '0;
      s_adr   <= '0;
      s_req   <= 1'b0;
      s_write <= 1'b0;
      s_sel   <= 2'b11;
      s_wdata <= '0;
      gnt     <= 2'b00;
      err     <= 1'b0;
    end else begin
      if (err_clr) begin
        err <= 1'b0;
      end
      unique case (state_q)
        StIdle: begin
          if (any_req) begin
            state_q <= StBusy;
            last_q  <= winner;
            cnt_q   <= '0;
            s_req   <= 1'b1;
            if (winner) begin
              gnt     <= 2'b10;
              s_adr   <= m1_adr;
              s_write <= m1_write;
              s_sel   <= m1_sel;
              s_wdata <= m1_wdata;
            end else begin
              gnt     <= 2'b01;
              s_adr   <= m0_adr;
              s_write <= m0_write;
              s_sel   <= m0_sel;
              s_wdata <= m0_wdata;
            end
          end
        end
        StBusy: begin
          if (done) begin
            state_q <= StIdle;
            s_req   <= 1'b0;
            s_write <= 1'b0;
            gnt     <= 2'b00;
            // Placed after the clear so a same-cycle abort keeps the flag set.
            if (timeout_hit) begin
              err <= 1'b1;
            end
          end else begin
            cnt_q <= cnt_q + 16'd1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
